// File: rtl/bridge_arb_pkg.sv
// Shared types and constants for the bridge request arbiter.
// Holds the FSM state encoding and the transfer-direction values.
package bridge_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } arb_state_t;

  localparam logic RD0 = 1'b0;
  localparam logic WR1 = 1'b1;

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
// The request vector is doubled so that the wrap becomes a plain linear scan.
module rr_arb_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grantOh_o,
  output logic [IDX_W-1:0]   grantIdx_o,
  output logic               anyValid_o
);

  logic [2*NUM_REQ-1:0] doubleReq;
  logic                 found;
  logic [IDX_W-1:0]     idx;

  assign doubleReq = {req_i, req_i};

  // Bits below ptr in the low copy are skipped; the high copy supplies the wrap.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < 2*NUM_REQ; i++) begin
      if (!found && doubleReq[i] && (i >= int'(ptr_i))) begin
        found = 1'b1;
        idx   = IDX_W'(i % NUM_REQ);
      end
    end
  end

  always_comb begin
    grantOh_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      grantOh_o[k] = found && (idx == IDX_W'(k));
    end
  end

  assign grantIdx_o = idx;
  assign anyValid_o = found;

endmodule

// File: rtl/bridge_req_arbiter.sv
// Shares one downstream request port among NUM_REQ requesters, round-robin,
// one transaction in flight; read data and timeouts are routed to the issuer.
module bridge_req_arbiter
  import bridge_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                          i_clk_ahb,
  input  logic                          i_rstn_ahb,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_rd0_wr1,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wr_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [NUM_REQ-1:0]            o_req_rd_valid,
  output logic [NUM_REQ-1:0]            o_req_err,
  output logic [DATA_WIDTH-1:0]         o_req_rd_data,
  output logic                          o_valid,
  output logic                          o_rd0_wr1,
  output logic [ADDR_WIDTH-1:0]         o_addr,
  output logic [DATA_WIDTH-1:0]         o_wr_data,
  input  logic                          i_ready,
  input  logic                          i_rd_valid,
  input  logic [DATA_WIDTH-1:0]         i_rd_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  arb_state_t             stateQ;
  logic [IDX_W-1:0]       ptrQ, ptrD;
  logic [IDX_W-1:0]       grantIdxQ;
  logic [NUM_REQ-1:0]     grantOhQ;
  logic [CNT_W-1:0]       cntQ, cntD;
  logic                   validQ;
  logic                   rd0Wr1Q;
  logic [ADDR_WIDTH-1:0]  addrQ;
  logic [DATA_WIDTH-1:0]  wrDataQ;
  logic [NUM_REQ-1:0]     reqReadyQ;
  logic [NUM_REQ-1:0]     reqRdValidQ;
  logic [NUM_REQ-1:0]     reqErrQ;
  logic [DATA_WIDTH-1:0]  reqRdDataQ;

  logic [NUM_REQ-1:0]     pickOh;
  logic [IDX_W-1:0]       pickIdx;
  logic                   pickAny;
  logic                   selDir;
  logic [ADDR_WIDTH-1:0]  selAddr;
  logic [DATA_WIDTH-1:0]  selWrData;

  rr_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) uPick (
    .req_i      (i_req_valid),
    .ptr_i      (ptrQ),
    .grantOh_o  (pickOh),
    .grantIdx_o (pickIdx),
    .anyValid_o (pickAny)
  );

  always_comb begin
    selDir    = 1'b0;
    selAddr   = '0;
    selWrData = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pickOh[k]) begin
        selDir    = i_req_rd0_wr1[k];
        selAddr   = i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        selWrData = i_req_wr_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign ptrD = (grantIdxQ == IDX_W'(NUM_REQ - 1)) ? '0 : grantIdxQ + IDX_W'(1);
  assign cntD = cntQ + CNT_W'(1);

  // Pulses default low each cycle; a data return in the timeout cycle still wins.
  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      stateQ      <= IDLE;
      ptrQ        <= '0;
      grantIdxQ   <= '0;
      grantOhQ    <= '0;
      cntQ        <= '0;
      validQ      <= 1'b0;
      rd0Wr1Q     <= 1'b0;
      addrQ       <= '0;
      wrDataQ     <= '0;
      reqReadyQ   <= '0;
      reqRdValidQ <= '0;
      reqErrQ     <= '0;
      reqRdDataQ  <= '0;
    end else begin
      reqReadyQ   <= '0;
      reqRdValidQ <= '0;
      reqErrQ     <= '0;
      case (stateQ)
        IDLE: begin
          if (pickAny) begin
            grantIdxQ <= pickIdx;
            grantOhQ  <= pickOh;
            validQ    <= 1'b1;
            rd0Wr1Q   <= selDir;
            addrQ     <= selAddr;
            wrDataQ   <= selWrData;
            stateQ    <= ISSUE;
          end
        end
        ISSUE: begin
          if (i_ready) begin
            validQ    <= 1'b0;
            reqReadyQ <= grantOhQ;
            ptrQ      <= ptrD;
            if (rd0Wr1Q == WR1) begin
              stateQ <= IDLE;
            end else begin
              stateQ <= WAIT_RD;
              cntQ   <= '0;
            end
          end
        end
        WAIT_RD: begin
          if (i_rd_valid) begin
            reqRdDataQ  <= i_rd_data;
            reqRdValidQ <= grantOhQ;
            stateQ      <= IDLE;
          end else begin
            cntQ <= cntD;
            if (cntD == CNT_W'(RD_TIMEOUT)) begin
              reqErrQ <= grantOhQ;
              stateQ  <= IDLE;
            end
          end
        end
        default: stateQ <= IDLE;
      endcase
    end
  end

  assign o_req_ready    = reqReadyQ;
  assign o_req_rd_valid = reqRdValidQ;
  assign o_req_err      = reqErrQ;
  assign o_req_rd_data  = reqRdDataQ;
  assign o_valid        = validQ;
  assign o_rd0_wr1      = rd0Wr1Q;
  assign o_addr         = addrQ;
  assign o_wr_data      = wrDataQ;

endmodule

// File: tb/tb_bridge_req_arbiter.sv
// Bench for bridge_req_arbiter: directed scenarios plus randomized transactions
// compared against a transaction-level round-robin model.
module tb_bridge_req_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [N-1:0]    i_req_valid;
  logic [N-1:0]    i_req_rd0_wr1;
  logic [N*AW-1:0] i_req_addr;
  logic [N*DW-1:0] i_req_wr_data;
  logic [N-1:0]    o_req_ready;
  logic [N-1:0]    o_req_rd_valid;
  logic [N-1:0]    o_req_err;
  logic [DW-1:0]   o_req_rd_data;
  logic            o_valid;
  logic            o_rd0_wr1;
  logic [AW-1:0]   o_addr;
  logic [DW-1:0]   o_wr_data;
  logic            i_ready;
  logic            i_rd_valid;
  logic [DW-1:0]   i_rd_data;

  int checks = 0;
  int errors = 0;
  int ptrModel = 0;
  logic [DW-1:0] expRdData = '0;
  logic          mdlDir[N];
  logic [AW-1:0] mdlAddr[N];
  logic [DW-1:0] mdlData[N];

  bridge_req_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RD_TIMEOUT (TO)
  ) dut (
    .i_clk_ahb      (clk),
    .i_rstn_ahb     (rstn),
    .i_req_valid    (i_req_valid),
    .i_req_rd0_wr1  (i_req_rd0_wr1),
    .i_req_addr     (i_req_addr),
    .i_req_wr_data  (i_req_wr_data),
    .o_req_ready    (o_req_ready),
    .o_req_rd_valid (o_req_rd_valid),
    .o_req_err      (o_req_err),
    .o_req_rd_data  (o_req_rd_data),
    .o_valid        (o_valid),
    .o_rd0_wr1      (o_rd0_wr1),
    .o_addr         (o_addr),
    .o_wr_data      (o_wr_data),
    .i_ready        (i_ready),
    .i_rd_valid     (i_rd_valid),
    .i_rd_data      (i_rd_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first valid requester at or after ptr, wrapping.
  function automatic int pickModel(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return 0;
  endfunction

  task automatic applyStimulus(input int k, input logic dir, input logic [AW-1:0] a, input logic [DW-1:0] d);
    i_req_valid[k]              = 1'b1;
    i_req_rd0_wr1[k]            = dir;
    i_req_addr[k*AW +: AW]      = a;
    i_req_wr_data[k*DW +: DW]   = d;
    mdlDir[k]  = dir;
    mdlAddr[k] = a;
    mdlData[k] = d;
  endtask

  // Runs one full transaction; rdDelay 0 means the read is left to time out.
  task automatic serveOne(input int readyDelay, input int rdDelay, input logic [DW-1:0] rdData,
                          input bit dropEarly, input bit dropAll);
    int w;
    logic [N-1:0] oh;
    w = pickModel(i_req_valid, ptrModel);
    oh = '0;
    oh[w] = 1'b1;
    @(negedge clk);
    checkOutput("issueValid", o_valid, 1);
    checkOutput("issueAddr", o_addr, mdlAddr[w]);
    checkOutput("issueDir", o_rd0_wr1, mdlDir[w]);
    checkOutput("issueData", o_wr_data, mdlData[w]);
    if (dropEarly) i_req_valid[w] = 1'b0;
    for (int c = 0; c < readyDelay; c++) begin
      @(negedge clk);
      checkOutput("holdValid", o_valid, 1);
      checkOutput("holdAddr", o_addr, mdlAddr[w]);
      checkOutput("holdNoReady", o_req_ready, 0);
    end
    i_ready = 1'b1;
    @(negedge clk);
    checkOutput("readyPulse", o_req_ready, oh);
    checkOutput("acceptDropsValid", o_valid, 0);
    i_ready = 1'b0;
    ptrModel = (w + 1) % N;
    if (dropAll) i_req_valid = '0;
    if (mdlDir[w] == 1'b0) begin
      if (rdDelay > 0) begin
        for (int c = 1; c < rdDelay; c++) begin
          @(negedge clk);
          checkOutput("waitQuiet", {o_req_rd_valid, o_req_err}, 0);
        end
        i_rd_valid = 1'b1;
        i_rd_data  = rdData;
        @(negedge clk);
        checkOutput("rdValidRoute", o_req_rd_valid, oh);
        checkOutput("rdData", o_req_rd_data, rdData);
        checkOutput("rdNoErr", o_req_err, 0);
        i_rd_valid = 1'b0;
        expRdData  = rdData;
      end else begin
        for (int c = 1; c < TO; c++) begin
          @(negedge clk);
          checkOutput("timeoutQuiet", {o_req_rd_valid, o_req_err}, 0);
        end
        @(negedge clk);
        checkOutput("timeoutErr", o_req_err, oh);
        checkOutput("timeoutNoRd", o_req_rd_valid, 0);
        i_rd_valid = 1'b1;
        i_rd_data  = rdData;
        @(negedge clk);
        checkOutput("lateRdIgnored", o_req_rd_valid, 0);
        checkOutput("lateNoErr", o_req_err, 0);
        checkOutput("lateRdData", o_req_rd_data, expRdData);
        i_rd_valid = 1'b0;
      end
    end
  endtask

  initial begin
    i_req_valid   = '0;
    i_req_rd0_wr1 = '0;
    i_req_addr    = '0;
    i_req_wr_data = '0;
    i_ready       = 1'b0;
    i_rd_valid    = 1'b0;
    i_rd_data     = '0;
    for (int k = 0; k < N; k++) begin
      mdlDir[k] = 1'b0; mdlAddr[k] = '0; mdlData[k] = '0;
    end

    repeat (2) @(negedge clk);
    checkOutput("resetOutputs", {o_req_ready, o_req_rd_valid, o_req_err, o_req_rd_data,
                                 o_valid, o_rd0_wr1, o_addr, o_wr_data}, 0);
    rstn = 1'b1;

    // Stray read data in IDLE.
    @(negedge clk);
    i_rd_valid = 1'b1;
    i_rd_data  = 32'h1234_5678;
    @(negedge clk);
    checkOutput("strayNoRdValid", o_req_rd_valid, 0);
    checkOutput("strayRdDataHeld", o_req_rd_data, expRdData);
    checkOutput("strayNoIssue", o_valid, 0);
    i_rd_valid = 1'b0;

    // Single write, read routing, timeout, read/timeout tie, early drop.
    applyStimulus(0, 1'b1, 32'h100, 32'hA5A5);
    serveOne(0, 0, '0, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 32'h200, 32'h0);
    serveOne(1, 4, 32'hDEAD_BEEF, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 32'h300, 32'h0);
    serveOne(0, 0, 32'h5555_AAAA, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 32'h700, 32'h0);
    serveOne(0, TO, 32'hCAFE_0001, 1'b0, 1'b1);
    applyStimulus(2, 1'b1, 32'h800, 32'h77);
    serveOne(1, 0, '0, 1'b1, 1'b1);

    // Reset abort while waiting for read data.
    applyStimulus(0, 1'b0, 32'h400, 32'h0);
    @(negedge clk);
    checkOutput("abortIssue", o_valid, 1);
    i_ready = 1'b1;
    @(negedge clk);
    checkOutput("abortAccept", o_req_ready, 3'b001);
    i_ready = 1'b0;
    i_req_valid = '0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checkOutput("abortOutputsZero", {o_req_ready, o_req_rd_valid, o_req_err, o_req_rd_data,
                                     o_valid, o_rd0_wr1, o_addr, o_wr_data}, 0);
    ptrModel  = 0;
    expRdData = '0;
    @(negedge clk);
    checkOutput("abortNoPulse", {o_req_rd_valid, o_req_err}, 0);
    rstn = 1'b1;

    // Contention after reset: both held, grants alternate from requester 0.
    applyStimulus(1, 1'b1, 32'h510, 32'h11);
    applyStimulus(0, 1'b1, 32'h500, 32'h22);
    for (int t = 0; t < 4; t++) begin
      serveOne(3, 0, '0, 1'b0, 1'b0);
    end
    i_req_valid = '0;
    @(negedge clk);
    checkOutput("contentionIdle", o_valid, 0);

    // Randomized transactions against the model.
    for (int it = 0; it < 40; it++) begin
      logic [N-1:0] mask;
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int k = 0; k < N; k++) begin
        if (mask[k]) applyStimulus(k, 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
      serveOne(int'($urandom_range(0, 2)), int'($urandom_range(0, TO)), $urandom,
               1'($urandom_range(0, 1)), 1'b1);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
